fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives the instruction-memory read request.
- Predicts next PC through a direct-mapped BTB with 2-bit saturating counters.
- Produces instr/npc/taken plus the IF/ID enable/flush controls; accepts redirects and BTB updates from the branch-resolve stage.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of 2, minimum 2.
- BTB_IDX, $clog2(BTB_ENTRIES), index width (derived).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction memory returned valid data this cycle.
- iload  in  32  instruction word from memory.
- imemREN  out  1  instruction read enable.
- imemaddr  out  32  fetch address (current PC).
- stall  in  1  hazard unit: hold fetch and IF/ID.
- halt  in  1  decode saw HALT; stop fetching.
- redirect  in  1  mispredict or jump resolved; load redirect_pc.
- redirect_pc  in  32  corrected PC.
- upd_valid  in  1  BTB update strobe for a resolved branch.
- upd_pc  in  32  PC of the resolved branch.
- upd_target  in  32  resolved branch target.
- upd_taken  in  1  resolved direction.
- instr  out  32  fetched word to IF/ID.
- npc  out  32  PC+4 of the fetched word to IF/ID.
- taken  out  1  prediction made for this word to IF/ID.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID inserts a bubble.

Behaviour:
- Reset: PC=PC_INIT, halted=0, all BTB valid=0, counters=2'b01.
- Combinational outputs: imemaddr=PC; imemREN=~halted; instr=iload; npc=PC+4 (32-bit wrap, no carry out).
- Lookup (combinational on PC):
  - idx = PC[BTB_IDX+1:2]; tag = PC[31:BTB_IDX+2].
  - hit = valid[idx] & tag match.
  - taken = hit & ctr[idx][1].
  - pred_pc = taken ? target[idx] : PC+4.
- PC update, in priority order, on each CLK edge:
  1. redirect: PC<=redirect_pc; halted<=0. Overrides stall, ihit and halt (a halt seen with redirect is on the wrong path).
  2. halted or halt: PC holds; halted<=1 (sticky until reset or redirect).
  3. stall: PC holds.
  4. ihit: PC<=pred_pc.
  5. else PC holds (waiting on memory).
- IF/ID controls:
  - ifid_en = redirect | ~stall.
  - ifid_flush = redirect | halted | halt | ~ihit.
  - Result: a miss or halt inserts a bubble; stall freezes IF/ID.
- BTB update on upd_valid, with i = upd_pc index and t = upd_pc tag:
  - Tag match: ctr saturates up (max 2'b11) if upd_taken, down (min 2'b00) otherwise; target<=upd_target if upd_taken.
  - Miss and upd_taken: allocate/overwrite entry i with valid=1, tag=t, target=upd_target, ctr=2'b10.
  - Miss and ~upd_taken: no write.
- Same-cycle update and lookup of the same index: lookup sees pre-update contents (no bypass).
- upd_valid is honoured during stall, halt and redirect.
- Reset asserted mid-fetch: PC and BTB return to reset values immediately; imemREN follows ~halted=1.

Optional Feature:
- Macro FETCH_BTB_EN.
- Defined: BTB and prediction as above.
- Undefined: no BTB storage; taken=0; pred_pc=PC+4; upd_* ignored. All other behaviour unchanged.

Test Plan:
- Reset with PC_INIT=0, ihit=1 for 3 cycles -> imemaddr 0,4,8; npc 4,8,12; taken=0; ifid_en=1, ifid_flush=0.
- ihit=0 for 2 cycles at PC=0x10 -> PC holds 0x10; ifid_flush=1, ifid_en=1; resumes to 0x14 on ihit.
- upd_valid, upd_pc=0x20, upd_target=0x80, upd_taken=1; later fetch 0x20 with ihit -> taken=1, next imemaddr=0x80. Two not-taken updates -> ctr 00; taken=0, next 0x24.
- stall=1 and redirect=1 with redirect_pc=0x200 in the same cycle -> PC=0x200; ifid_en=1, ifid_flush=1.
- halt=1 at PC=0x40 -> imemREN=0 next cycle, PC frozen, flush each cycle. A later redirect to 0x100 resumes fetch.
- Aliasing with BTB_ENTRIES=16: entry for 0x20, then taken update at 0x420 -> entry replaced; 0x20 misses (taken=0), 0x420 hits.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues the I-mem read, predicts the next PC
// and drives the IF/ID enable/flush controls.
// Optional macro FETCH_BTB_EN: when defined, a direct-mapped BTB with 2-bit
// saturating counters predicts taken branches; when undefined, fetch is PC+4 only.
module fetch_unit #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        taken,
  output logic        ifid_en,
  output logic        ifid_flush
);

  localparam int unsigned BTB_IDX = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W   = 30 - BTB_IDX;

  logic [31:0] r_pc;
  logic        r_halted;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pred_pc;
  logic        w_taken;
  logic        w_unused_upd;

  assign w_pc_plus4 = r_pc + 32'd4;

  assign imemaddr   = r_pc;
  assign imemREN    = ~r_halted;
  assign instr      = iload;
  assign npc        = w_pc_plus4;
  assign taken      = w_taken;
  assign ifid_en    = redirect | ~stall;
  assign ifid_flush = redirect | r_halted | halt | ~ihit;

`ifdef FETCH_BTB_EN
  logic [BTB_IDX-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic [BTB_IDX-1:0] w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_upd_hit;

  logic               r_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]   r_tag    [BTB_ENTRIES];
  logic [31:0]        r_target [BTB_ENTRIES];
  logic [1:0]         r_ctr    [BTB_ENTRIES];

  assign w_idx     = r_pc[BTB_IDX+1:2];
  assign w_tag     = r_pc[31:BTB_IDX+2];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_taken   = w_hit & r_ctr[w_idx][1];
  assign w_pred_pc = w_taken ? r_target[w_idx] : w_pc_plus4;

  assign w_upd_idx = upd_pc[BTB_IDX+1:2];
  assign w_upd_tag = upd_pc[31:BTB_IDX+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Branch byte offset never reaches the BTB.
  assign w_unused_upd = ^upd_pc[1:0];

  // BTB training: counter update on tag match, allocate on a taken miss.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        r_valid[BTB_IDX'(i)]  <= 1'b0;
        r_tag[BTB_IDX'(i)]    <= '0;
        r_target[BTB_IDX'(i)] <= '0;
        r_ctr[BTB_IDX'(i)]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_taken) begin
          if (r_ctr[w_upd_idx] != 2'b11) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
          r_target[w_upd_idx] <= upd_target;
        end else if (r_ctr[w_upd_idx] != 2'b00) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end
`else
  assign w_taken      = 1'b0;
  assign w_pred_pc    = w_pc_plus4;
  assign w_unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
`endif

  // PC and sticky halt: redirect > halt > stall > ihit > wait on memory.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc     <= PC_INIT;
      r_halted <= 1'b0;
    end else if (redirect) begin
      r_pc     <= redirect_pc;
      r_halted <= 1'b0;
    end else if (r_halted || halt) begin
      r_halted <= 1'b1;
    end else if (!stall && ihit) begin
      r_pc <= w_pred_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle scoreboard against a small
// reference model, plus directed constant checks for each scenario.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, stall, halt, redirect, upd_valid, upd_taken;
  logic [31:0] iload, redirect_pc, upd_pc, upd_target;
  logic        imemREN, taken, ifid_en, ifid_flush;
  logic [31:0] imemaddr, instr, npc;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        ren;
    logic [31:0] npc;
    logic        tk;
    logic        en;
    logic        fl;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;

  logic [31:0] m_pc;
  logic        m_halted;
`ifdef FETCH_BTB_EN
  logic        m_valid  [16];
  logic [25:0] m_tag    [16];
  logic [31:0] m_target [16];
  logic [1:0]  m_ctr    [16];
  localparam logic BTB_ON = 1'b1;
`else
  localparam logic BTB_ON = 1'b0;
`endif

  fetch_unit #(.PC_INIT(32'h0), .BTB_ENTRIES(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall), .halt(halt),
    .redirect(redirect), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .instr(instr), .npc(npc), .taken(taken), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: compare DUT outputs mid-cycle against the expectation queued at drive time.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      vectors++;
      if (imemaddr !== sb_e.addr) begin miscompares++; $display("FAIL imemaddr got %h want %h", imemaddr, sb_e.addr); end
      vectors++;
      if (imemREN !== sb_e.ren) begin miscompares++; $display("FAIL imemREN got %b want %b", imemREN, sb_e.ren); end
      vectors++;
      if (npc !== sb_e.npc) begin miscompares++; $display("FAIL npc got %h want %h", npc, sb_e.npc); end
      vectors++;
      if (taken !== sb_e.tk) begin miscompares++; $display("FAIL taken got %b want %b at pc %h", taken, sb_e.tk, sb_e.addr); end
      vectors++;
      if (ifid_en !== sb_e.en) begin miscompares++; $display("FAIL ifid_en got %b want %b", ifid_en, sb_e.en); end
      vectors++;
      if (ifid_flush !== sb_e.fl) begin miscompares++; $display("FAIL ifid_flush got %b want %b", ifid_flush, sb_e.fl); end
      vectors++;
      if (instr !== sb_e.ins) begin miscompares++; $display("FAIL instr got %h want %h", instr, sb_e.ins); end
    end
  end

  task automatic model_reset();
    m_pc     = 32'h0;
    m_halted = 1'b0;
`ifdef FETCH_BTB_EN
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 2'b01;
    end
`endif
  endtask

  // One clock of stimulus: drive, queue the expectation, then advance the model at the edge.
  task automatic cycle(input logic i_hit, input logic i_stall, input logic i_halt,
                       input logic i_redir, input logic [31:0] i_rpc,
                       input logic u_v, input logic [31:0] u_pc,
                       input logic [31:0] u_tgt, input logic u_tk);
    exp_t        e;
    logic        mtk;
    logic [31:0] pred;
`ifdef FETCH_BTB_EN
    logic [3:0]  ix, ui;
    logic [25:0] ut;
`endif
    ihit = i_hit; stall = i_stall; halt = i_halt; redirect = i_redir;
    redirect_pc = i_rpc; upd_valid = u_v; upd_pc = u_pc; upd_target = u_tgt;
    upd_taken = u_tk; iload = $urandom;
    mtk  = 1'b0;
    pred = m_pc + 32'd4;
`ifdef FETCH_BTB_EN
    ix = m_pc[5:2];
    mtk = m_valid[ix] && (m_tag[ix] == m_pc[31:6]) && m_ctr[ix][1];
    if (mtk) pred = m_target[ix];
`endif
    e.addr = m_pc;
    e.ren  = ~m_halted;
    e.npc  = m_pc + 32'd4;
    e.tk   = mtk;
    e.en   = i_redir | ~i_stall;
    e.fl   = i_redir | m_halted | i_halt | ~i_hit;
    e.ins  = iload;
    exp_q.push_back(e);
    @(posedge CLK);
`ifdef FETCH_BTB_EN
    if (u_v) begin
      ui = u_pc[5:2]; ut = u_pc[31:6];
      if (m_valid[ui] && m_tag[ui] == ut) begin
        if (u_tk) begin
          if (m_ctr[ui] != 2'b11) m_ctr[ui] = m_ctr[ui] + 2'd1;
          m_target[ui] = u_tgt;
        end else if (m_ctr[ui] != 2'b00) begin
          m_ctr[ui] = m_ctr[ui] - 2'd1;
        end
      end else if (u_tk) begin
        m_valid[ui] = 1'b1; m_tag[ui] = ut; m_target[ui] = u_tgt; m_ctr[ui] = 2'b10;
      end
    end
`endif
    if (i_redir) begin
      m_pc = i_rpc; m_halted = 1'b0;
    end else if (m_halted || i_halt) begin
      m_halted = 1'b1;
    end else if (!i_stall && i_hit) begin
      m_pc = pred;
    end
    #1;
  endtask

  task automatic fetch(input logic hit);
    cycle(hit, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic redir(input logic [31:0] pc);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic btb_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, pc, tgt, tk);
  endtask

  task automatic test_reset();
    nRST = 1'b0; ihit = 0; stall = 0; halt = 0; redirect = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0; iload = 0;
    model_reset();
    #12;
    vectors++;
    if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", imemaddr, 32'h0); end
    vectors++;
    if (imemREN !== 1'b1) begin miscompares++; $display("FAIL reset_ren got %b want 1", imemREN); end
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_fetch_seq();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (imemaddr !== 32'(4 * k)) begin miscompares++; $display("FAIL seq_addr got %h want %h", imemaddr, 32'(4 * k)); end
      fetch(1'b1);
    end
    vectors++;
    if (imemaddr !== 32'hc) begin miscompares++; $display("FAIL seq_end got %h want %h", imemaddr, 32'hc); end
    fetch(1'b1);
  endtask

  task automatic test_miss();
    fetch(1'b0);
    fetch(1'b0);
    vectors++;
    if (imemaddr !== 32'h10) begin miscompares++; $display("FAIL miss_hold got %h want %h", imemaddr, 32'h10); end
    fetch(1'b1);
    vectors++;
    if (imemaddr !== 32'h14) begin miscompares++; $display("FAIL miss_resume got %h want %h", imemaddr, 32'h14); end
  endtask

  task automatic test_btb();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 32'h80, 1'b1);
    vectors++;
    if (taken !== BTB_ON) begin miscompares++; $display("FAIL btb_taken got %b want %b", taken, BTB_ON); end
    fetch(1'b1);
    vectors++;
    if (imemaddr !== (BTB_ON ? 32'h80 : 32'h24)) begin
      miscompares++; $display("FAIL btb_target got %h want %h", imemaddr, BTB_ON ? 32'h80 : 32'h24);
    end
    btb_upd(32'h20, 32'h0, 1'b0);
    btb_upd(32'h20, 32'h0, 1'b0);
    redir(32'h20);
    vectors++;
    if (taken !== 1'b0) begin miscompares++; $display("FAIL btb_nt got %b want 0", taken); end
    fetch(1'b1);
    vectors++;
    if (imemaddr !== 32'h24) begin miscompares++; $display("FAIL btb_nt_next got %h want %h", imemaddr, 32'h24); end
  endtask

  task automatic test_stall_redirect();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    vectors++;
    if (imemaddr !== 32'h24) begin miscompares++; $display("FAIL stall_hold got %h want %h", imemaddr, 32'h24); end
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0);
    vectors++;
    if (imemaddr !== 32'h200) begin miscompares++; $display("FAIL stall_redir got %h want %h", imemaddr, 32'h200); end
  endtask

  task automatic test_halt();
    redir(32'h40);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    vectors++;
    if (imemREN !== 1'b0) begin miscompares++; $display("FAIL halt_ren got %b want 0", imemREN); end
    fetch(1'b1);
    fetch(1'b1);
    vectors++;
    if (imemaddr !== 32'h40) begin miscompares++; $display("FAIL halt_hold got %h want %h", imemaddr, 32'h40); end
    redir(32'h100);
    vectors++;
    if (imemaddr !== 32'h100 || imemREN !== 1'b1) begin
      miscompares++; $display("FAIL halt_resume got %h/%b want %h/1", imemaddr, imemREN, 32'h100);
    end
    fetch(1'b1);
    // halt on the wrong path is cancelled by a same-cycle redirect
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h60, 1'b0, 32'h0, 32'h0, 1'b0);
    vectors++;
    if (imemREN !== 1'b1) begin miscompares++; $display("FAIL halt_redir_ren got %b want 1", imemREN); end
  endtask

  task automatic test_alias();
    btb_upd(32'h20, 32'h80, 1'b1);
    btb_upd(32'h20, 32'h80, 1'b1);
    btb_upd(32'h420, 32'h300, 1'b1);
    redir(32'h20);
    vectors++;
    if (taken !== 1'b0) begin miscompares++; $display("FAIL alias_old got %b want 0", taken); end
    redir(32'h420);
    vectors++;
    if (taken !== BTB_ON) begin miscompares++; $display("FAIL alias_new got %b want %b", taken, BTB_ON); end
    fetch(1'b1);
    vectors++;
    if (imemaddr !== (BTB_ON ? 32'h300 : 32'h424)) begin
      miscompares++; $display("FAIL alias_target got %h want %h", imemaddr, BTB_ON ? 32'h300 : 32'h424);
    end
  endtask

  task automatic test_wrap();
    redir(32'hffff_fffc);
    vectors++;
    if (npc !== 32'h0) begin miscompares++; $display("FAIL wrap_npc got %h want %h", npc, 32'h0); end
    fetch(1'b1);
    vectors++;
    if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h want %h", imemaddr, 32'h0); end
  endtask

  task automatic test_random();
    logic [31:0] rpc, upc;
    for (int n = 0; n < 200; n++) begin
      rpc = 32'($urandom_range(0, 511)) << 2;
      upc = 32'($urandom_range(0, 511)) << 2;
      cycle(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 17) == 0,
            ($urandom % 6) == 0, rpc, ($urandom % 3) == 0, upc,
            32'($urandom_range(0, 511)) << 2, ($urandom % 3) != 0);
    end
  endtask

  task automatic test_reset_mid();
    redir(32'h420);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    nRST = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (imemREN !== 1'b1 || imemaddr !== 32'h0) begin
      miscompares++; $display("FAIL mid_reset got %h/%b want %h/1", imemaddr, imemREN, 32'h0);
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    redir(32'h420);
    vectors++;
    if (taken !== 1'b0) begin miscompares++; $display("FAIL mid_reset_btb got %b want 0", taken); end
    fetch(1'b1);
  endtask

  initial begin
    test_reset();
    test_fetch_seq();
    test_miss();
    test_btb();
    test_stall_redirect();
    test_halt();
    test_alias();
    test_wrap();
    test_random();
    test_reset_mid();
    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
